timer_bcd_countdown: RTL and testbench
======================================

# timer_bcd_countdown

BCD countdown timer for the irrigation controller: it holds an MM:SS watering duration and counts it down at a 1 Hz rate derived from the system clock. It sits directly upstream of the display digit multiplexer, feeding its four 4-bit BCD inputs. It also drives the valve-enable (`running`) and end-of-cycle (`done`) signals consumed by the irrigation control logic.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per one-second tick (≥2); benches use a small value.
- `clk`  in  1  system clock, all logic rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load`  in  1  single-cycle pulse; captures `load_m_t`, `load_m_u`, `load_s_t`, `load_s_u`.
- `load_m_t`, `load_m_u`, `load_s_t`, `load_s_u`  in  4 each  preset BCD digits: minutes tens/units, seconds tens/units.
- `start`  in  1  single-cycle pulse; begin or resume counting.
- `pause`  in  1  single-cycle pulse; freeze counting.
- `digit0`  out  4  seconds units → mux `bin_number0`.
- `digit1`  out  4  seconds tens → mux `bin_number1`.
- `digit2`  out  4  minutes units → mux `bin_number2`.
- `digit3`  out  4  minutes tens → mux `bin_number3`.
- `running`  out  1  high while in RUN (valve on).
- `expired`  out  1  high while in DONE.
- `done`  out  1  one-cycle pulse on entry to DONE.

## Operation
- States: IDLE, RUN, PAUSED, DONE. Reset → IDLE; all digits 0, all outputs 0, prescaler 0.
- Input priority per cycle: `load` > `start` > `pause`.
- `load` (any state) → IDLE; digits take the saturated preset; prescaler cleared; `done` not generated.
- Saturation on load: any unit digit >9 → 9; `load_s_t` >5 → 5; `load_m_t` >9 → 9.
- IDLE + `start`: if the value is 00:00 → DONE; else → RUN with prescaler cleared.
- RUN + `pause` → PAUSED; prescaler and digits hold.
- PAUSED + `start` → RUN; prescaler resumes from its held value.
- DONE: `start` and `pause` are ignored; only `load` or reset exits.
- Prescaler counts 0..TICK_DIV-1, but only in RUN. The tick fires when count==TICK_DIV-1 and the count wraps to 0.
- Tick decrement chain, digit0→digit3:
  - A digit at 0 borrows from the next digit and reloads its max: 9 for units and minutes tens, 5 for seconds tens.
  - Otherwise the digit decrements and borrowing stops.
- The tick edge that produces 00:00 also moves the state to DONE. The count never wraps below 00:00.
- `pause` on the same cycle as a tick: the tick is discarded (digits hold) and the state moves to PAUSED.

## Timing
- All outputs are registered.
- `start` sampled at edge k → `running`=1 after edge k. First decrement at edge k+TICK_DIV, then every TICK_DIV cycles.
- `done` is high for exactly the first cycle in DONE. `expired` rises with it and stays high.
- `load` sampled at edge k → digits valid after edge k; `running`/`expired` cleared after the same edge.
- `rst_n` low at any time, including mid-count or in DONE: outputs clear immediately (asynchronous). Release is synchronous to the next edge with no input activity assumed in that cycle.
- Duration 00:01 from start: `done` high in the cycle after edge k+TICK_DIV.

## Structure
- Package `timer_pkg`:
  - state enum `timer_state_t` (IDLE, RUN, PAUSED, DONE);
  - constants `BCD_MAX_UNITS`=9, `BCD_MAX_SEC_TENS`=5, `BCD_MAX_MIN_TENS`=9.
- Sub-module `bcd_digit_down`, instantiated four times in a borrow chain:
  - parameter MAX;
  - inputs: load, load value, decrement enable;
  - outputs: digit, borrow-out (digit==0 and dec).
- Top level contains the FSM, prescaler, saturation logic and `done` pulse register.

## Test plan
- Reset with TICK_DIV=4, then load 01:05, start: digits step 01:05→01:04→…→01:00→00:59; `running`=1 throughout; each step exactly 4 cycles apart.
- Load 00:02, start: `done` is a single-cycle pulse 8 cycles after start (TICK_DIV=4); `expired` then stays 1, `running`=0, digits 00:00. A subsequent start has no effect.
- Load 00:03, start, pause after 6 cycles, idle 20 cycles, start: digits frozen at 00:02 while paused; next decrement 2 cycles after resume.
- Load digits 12, 7, 15, 9 (m_t, m_u, s_t, s_u): display reads 97:59. Load 00:00 then start: `done` pulse on the next cycle.
- Assert `rst_n` low mid-RUN at 00:41: all digits and outputs 0 immediately; after release, start with 00:00 goes to DONE.
- Load and start in the same cycle while RUN: new value loaded, state IDLE, `running`=0, no `done`.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } timer_state_t;

    localparam logic [3:0] BCD_MAX_UNITS    = 4'd9;
    localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;
    localparam logic [3:0] BCD_MAX_MIN_TENS = 4'd9;

    // Clamp a preset digit to the largest value its position can show.
    function automatic logic [3:0] bcd_sat(input logic [3:0] val, input logic [3:0] max);
        return (val > max) ? max : val;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of a down-counter; wraps to MAX and borrows when decremented at zero.
module bcd_digit_down #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic [3:0] digit,
    output logic       borrow
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    // Next digit value: load wins over decrement.
    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = load_val;
        end else if (dec) begin
            digit_d = (digit_q == 4'd0) ? MAX : (digit_q - 4'd1);
        end
    end

    // Digit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit  = digit_q;
    assign borrow = (digit_q == 4'd0) && dec;

endmodule

// File: rtl/timer_bcd_countdown.sv
// MM:SS BCD countdown timer with 1 Hz prescaler, run/pause control and end-of-cycle pulse.
module timer_bcd_countdown
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_m_t,
    input  logic [3:0] load_m_u,
    input  logic [3:0] load_s_t,
    input  logic [3:0] load_s_u,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic       running,
    output logic       expired,
    output logic       done
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    timer_state_t  state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          done_q, done_d;
    logic          tick;
    logic          tick_apply;
    logic          is_zero;
    logic          last_sec;
    logic          borrow0, borrow1, borrow2, borrow3;

    assign tick     = (presc_q == PRESC_LAST);
    assign is_zero  = (digit3 == 4'd0) && (digit2 == 4'd0) && (digit1 == 4'd0) && (digit0 == 4'd0);
    // The tick taken at 00:01 is the one that lands on 00:00.
    assign last_sec = (digit3 == 4'd0) && (digit2 == 4'd0) && (digit1 == 4'd0) && (digit0 == 4'd1);

    // FSM next state, prescaler next value and decrement enable; load > start > pause.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        tick_apply = 1'b0;
        if (load) begin
            state_d = IDLE;
            presc_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        presc_d = '0;
                        state_d = is_zero ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (!start && pause) begin
                        // A tick coinciding with pause is dropped.
                        state_d = PAUSED;
                    end else if (tick) begin
                        presc_d = '0;
                        if (!is_zero) begin
                            tick_apply = 1'b1;
                        end
                        if (last_sec || is_zero) begin
                            state_d = DONE;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                PAUSED: begin
                    if (start) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // done pulses only on the cycle the FSM first enters DONE.
    always_comb begin
        done_d = (state_d == DONE) && (state_q != DONE);
    end

    // State, prescaler and done pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

    bcd_digit_down #(.MAX(BCD_MAX_UNITS)) u_sec_units (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (bcd_sat(load_s_u, BCD_MAX_UNITS)),
        .dec      (tick_apply),
        .digit    (digit0),
        .borrow   (borrow0)
    );

    bcd_digit_down #(.MAX(BCD_MAX_SEC_TENS)) u_sec_tens (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (bcd_sat(load_s_t, BCD_MAX_SEC_TENS)),
        .dec      (borrow0),
        .digit    (digit1),
        .borrow   (borrow1)
    );

    bcd_digit_down #(.MAX(BCD_MAX_UNITS)) u_min_units (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (bcd_sat(load_m_u, BCD_MAX_UNITS)),
        .dec      (borrow1),
        .digit    (digit2),
        .borrow   (borrow2)
    );

    bcd_digit_down #(.MAX(BCD_MAX_MIN_TENS)) u_min_tens (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (bcd_sat(load_m_t, BCD_MAX_MIN_TENS)),
        .dec      (borrow2),
        .digit    (digit3),
        .borrow   (borrow3)
    );

    assign running = (state_q == RUN);
    assign expired = (state_q == DONE);
    assign done    = done_q;

    // Borrow out of the top digit cannot occur: RUN never ticks at 00:00.
    logic unused_borrow;
    assign unused_borrow = borrow3;

endmodule

// File: tb/tb_timer_bcd_countdown.sv
// Directed self-checking bench for timer_bcd_countdown with TICK_DIV = 4.
module tb_timer_bcd_countdown;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [3:0] load_m_t, load_m_u, load_s_t, load_s_u;
    logic       start;
    logic       pause;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic       running, expired, done;

    int checks;
    int errors;

    timer_bcd_countdown #(.TICK_DIV(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_m_t (load_m_t),
        .load_m_u (load_m_u),
        .load_s_t (load_s_t),
        .load_s_u (load_s_u),
        .start    (start),
        .pause    (pause),
        .digit0   (digit0),
        .digit1   (digit1),
        .digit2   (digit2),
        .digit3   (digit3),
        .running  (running),
        .expired  (expired),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  m_t, m_u, s_t, s_u;
        logic [15:0] disp;
    } load_vec_t;

    load_vec_t vecs [7];

    // Advance one clock edge, then settle 1 time unit past it.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] disp();
        return {digit3, digit2, digit1, digit0};
    endfunction

    function automatic logic [15:0] flags();
        return {13'd0, running, expired, done};
    endfunction

    task automatic do_load(input logic [3:0] mt, mu, st, su);
        load_m_t = mt; load_m_u = mu; load_s_t = st; load_s_u = su;
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic do_pause();
        pause = 1'b1;
        step(1);
        pause = 1'b0;
    endtask

    // flags() packs {running, expired, done} into the low 3 bits.
    localparam logic [15:0] F_NONE = 16'h0;
    localparam logic [15:0] F_RUN  = 16'h4;
    localparam logic [15:0] F_EXP  = 16'h2;
    localparam logic [15:0] F_DONE = 16'h3;

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        load = 1'b0; start = 1'b0; pause = 1'b0;
        load_m_t = 4'd0; load_m_u = 4'd0; load_s_t = 4'd0; load_s_u = 4'd0;

        vecs[0] = '{m_t: 4'd1,  m_u: 4'd2,  s_t: 4'd3,  s_u: 4'd4,  disp: 16'h1234};
        vecs[1] = '{m_t: 4'd12, m_u: 4'd7,  s_t: 4'd15, s_u: 4'd9,  disp: 16'h9759};
        vecs[2] = '{m_t: 4'd9,  m_u: 4'd10, s_t: 4'd6,  s_u: 4'd11, disp: 16'h9959};
        vecs[3] = '{m_t: 4'd0,  m_u: 4'd0,  s_t: 4'd0,  s_u: 4'd0,  disp: 16'h0000};
        vecs[4] = '{m_t: 4'd5,  m_u: 4'd9,  s_t: 4'd5,  s_u: 4'd9,  disp: 16'h5959};
        vecs[5] = '{m_t: 4'd15, m_u: 4'd15, s_t: 4'd15, s_u: 4'd15, disp: 16'h9959};
        vecs[6] = '{m_t: 4'd0,  m_u: 4'd0,  s_t: 4'd6,  s_u: 4'd0,  disp: 16'h0050};

        #12;
        check("reset_digits", disp(), 16'h0000);
        check("reset_flags", flags(), F_NONE);
        rst_n = 1'b1;
        step(1);

        // Load saturation table.
        for (int i = 0; i < 7; i++) begin
            do_load(vecs[i].m_t, vecs[i].m_u, vecs[i].s_t, vecs[i].s_u);
            check($sformatf("load_vec%0d", i), disp(), vecs[i].disp);
            check($sformatf("load_vec%0d_flags", i), flags(), F_NONE);
        end

        // 01:05 counts down with exactly 4 cycles between steps.
        begin
            logic [15:0] seq [7];
            seq[0] = 16'h0105; seq[1] = 16'h0104; seq[2] = 16'h0103; seq[3] = 16'h0102;
            seq[4] = 16'h0101; seq[5] = 16'h0100; seq[6] = 16'h0059;
            do_load(4'd0, 4'd1, 4'd0, 4'd5);
            do_start();
            check("count_start", disp(), seq[0]);
            check("count_start_flags", flags(), F_RUN);
            for (int i = 1; i < 7; i++) begin
                step(3);
                check($sformatf("count_hold%0d", i), disp(), seq[i-1]);
                step(1);
                check($sformatf("count_step%0d", i), disp(), seq[i]);
                check($sformatf("count_run%0d", i), flags(), F_RUN);
            end
        end

        // 00:02: done pulse 8 cycles after start, then sticky expired.
        do_load(4'd0, 4'd0, 4'd0, 4'd2);
        do_start();
        step(7);
        check("d2_before_done", flags(), F_RUN);
        step(1);
        check("d2_done_flags", flags(), F_DONE);
        check("d2_done_digits", disp(), 16'h0000);
        step(1);
        check("d2_after_done", flags(), F_EXP);
        do_start();
        do_pause();
        check("d2_start_ignored", flags(), F_EXP);
        check("d2_digits_hold", disp(), 16'h0000);

        // Pause/resume: prescaler resumes from held count.
        do_load(4'd0, 4'd0, 4'd0, 4'd3);
        do_start();
        step(6);
        check("pr_before_pause", disp(), 16'h0002);
        do_pause();
        check("pr_paused_flags", flags(), F_NONE);
        step(20);
        check("pr_frozen", disp(), 16'h0002);
        check("pr_frozen_flags", flags(), F_NONE);
        do_start();
        check("pr_resumed", flags(), F_RUN);
        step(1);
        check("pr_resume_hold", disp(), 16'h0002);
        step(1);
        check("pr_resume_step", disp(), 16'h0001);

        // Pause on the tick edge discards that tick.
        do_load(4'd0, 4'd0, 4'd1, 4'd0);
        do_start();
        step(3);
        do_pause();
        check("ptick_digits", disp(), 16'h0010);
        check("ptick_flags", flags(), F_NONE);

        // 00:00 start goes straight to DONE.
        do_load(4'd0, 4'd0, 4'd0, 4'd0);
        do_start();
        check("zero_start_done", flags(), F_DONE);
        step(1);
        check("zero_start_after", flags(), F_EXP);

        // Asynchronous reset mid-count at 00:41.
        do_load(4'd0, 4'd0, 4'd4, 4'd2);
        do_start();
        step(4);
        check("rst_pre_digits", disp(), 16'h0041);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_digits", disp(), 16'h0000);
        check("rst_async_flags", flags(), F_NONE);
        #3;
        rst_n = 1'b1;
        step(1);
        do_start();
        check("rst_zero_done", flags(), F_DONE);

        // Load and start together while running: load wins.
        do_load(4'd0, 4'd0, 4'd3, 4'd0);
        do_start();
        step(2);
        load_m_t = 4'd0; load_m_u = 4'd0; load_s_t = 4'd2; load_s_u = 4'd5;
        load = 1'b1;
        start = 1'b1;
        step(1);
        load = 1'b0;
        start = 1'b0;
        check("ls_digits", disp(), 16'h0025);
        check("ls_flags", flags(), F_NONE);
        step(5);
        check("ls_idle_digits", disp(), 16'h0025);
        check("ls_idle_flags", flags(), F_NONE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
